ssd_display_arbiter: RTL

- Shares the four-digit seven-segment display between two byte sources: UART receive path (rx) and UART transmit path (tx).
- Each source offers a byte with a valid/ack handshake. The arbiter grants one source round-robin and holds that byte on the display for a programmable time.
- Outputs drive the display controller's data, digit-enable and digit-point inputs directly.

---
 rtl/ssd_display_arbiter_if.sv | 23 ++
 rtl/ssd_display_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/ssd_display_arbiter_if.sv
// Byte-source handshakes and display-controller outputs for the seven-segment arbiter.
interface ssd_display_arbiter_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ack;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ack;
  logic [15:0] disp_data;
  logic [3:0]  disp_digits;
  logic [3:0]  disp_points;
  logic        busy;

  modport slave (
    input  rx_valid, rx_data, tx_valid, tx_data,
    output rx_ack, tx_ack, disp_data, disp_digits, disp_points, busy
  );

  modport master (
    output rx_valid, rx_data, tx_valid, tx_data,
    input  rx_ack, tx_ack, disp_data, disp_digits, disp_points, busy
  );
endinterface

// File: rtl/ssd_display_arbiter.sv
// Round-robin arbiter sharing the 4-digit display between UART rx and tx bytes;
// each granted byte is shown as {tag, 0, byte} for HOLD_CYCLES clocks.
module ssd_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter logic [3:0]  RX_TAG      = 4'hA,
  parameter logic [3:0]  TX_TAG      = 4'hB
) (
  input  logic                  clk,
  input  logic                  reset,
  ssd_display_arbiter_if.slave  bus
);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic { IDLE, SHOW } state_t;
  typedef enum logic { SRC_RX, SRC_TX } src_t;

  state_t           state, state_nxt;
  src_t             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rx_ack_q, rx_ack_nxt;
  logic             tx_ack_q, tx_ack_nxt;
  logic [15:0]      data_q, data_nxt;
  logic [3:0]       digits_q, digits_nxt;
  logic [3:0]       points_q, points_nxt;
  logic             busy_q, busy_nxt;
  logic             win_tx;

  // Hold counter never wraps below zero.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  // tx wins when it is the only requester, or on a tie when rx was served last.
  assign win_tx = bus.tx_valid && (!bus.rx_valid || last_grant == SRC_RX);

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    rx_ack_nxt     = 1'b0;
    tx_ack_nxt     = 1'b0;
    data_nxt       = data_q;
    digits_nxt     = digits_q;
    points_nxt     = points_q;
    busy_nxt       = busy_q;
    unique case (state)
      IDLE: begin
        if (bus.rx_valid || bus.tx_valid) begin
          state_nxt  = SHOW;
          cnt_nxt    = CNT_LOAD;
          busy_nxt   = 1'b1;
          digits_nxt = 4'b1011;
          points_nxt = 4'b1000;
          if (win_tx) begin
            tx_ack_nxt     = 1'b1;
            last_grant_nxt = SRC_TX;
            data_nxt       = {TX_TAG, 4'h0, bus.tx_data};
          end else begin
            rx_ack_nxt     = 1'b1;
            last_grant_nxt = SRC_RX;
            data_nxt       = {RX_TAG, 4'h0, bus.rx_data};
          end
        end
      end
      SHOW: begin
        // Byte stays on the digits after the hold; only the point marks it as live.
        if (cnt == '0) begin
          state_nxt  = IDLE;
          busy_nxt   = 1'b0;
          points_nxt = 4'b0000;
        end else begin
          cnt_nxt = sat_dec(cnt);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= SRC_TX;
      cnt        <= '0;
      rx_ack_q   <= 1'b0;
      tx_ack_q   <= 1'b0;
      data_q     <= 16'h0000;
      digits_q   <= 4'b0000;
      points_q   <= 4'b0000;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      rx_ack_q   <= rx_ack_nxt;
      tx_ack_q   <= tx_ack_nxt;
      data_q     <= data_nxt;
      digits_q   <= digits_nxt;
      points_q   <= points_nxt;
      busy_q     <= busy_nxt;
    end
  end

  assign bus.rx_ack      = rx_ack_q;
  assign bus.tx_ack      = tx_ack_q;
  assign bus.disp_data   = data_q;
  assign bus.disp_digits = digits_q;
  assign bus.disp_points = points_q;
  assign bus.busy        = busy_q;
endmodule
